// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE controller slice: tile-calculator FSM states
// and the tiling bundle that feeds the controller's W_ITERS/LEFT_PARAMS words.
package redmule_pkg;

    localparam int unsigned TilingSizeW = 16;

    typedef enum logic [2:0] {
        IDLE,
        DIV_M,
        DIV_N,
        DIV_K,
        MUL,
        DONE
    } tile_calc_state_e;

    typedef struct packed {
        logic [TilingSizeW-1:0] x_rows_iter;
        logic [TilingSizeW-1:0] x_rows_lftovr;
        logic [TilingSizeW-1:0] n_iters;
        logic [TilingSizeW-1:0] n_lftovr;
        logic [TilingSizeW-1:0] k_iters;
        logic [TilingSizeW-1:0] k_lftovr;
        logic [TilingSizeW-1:0] w_rows_iter;
        logic [TilingSizeW-1:0] tot_stores;
    } redmule_tiling_t;

endpackage

// File: rtl/redmule_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first step runs on the
// start edge itself, so q/r/done are ready SizeW cycles after start.
module redmule_seq_divider #(
    parameter int unsigned SizeW = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start,
    input  logic [SizeW-1:0] divisor,
    input  logic [SizeW-1:0] dividend,
    output logic [SizeW-1:0] q,
    output logic [SizeW-1:0] r,
    output logic             done
);

    localparam int unsigned CntW = $clog2(SizeW + 1);

    logic [SizeW-1:0] rem_q, quo_q, dvs_q;
    logic [CntW-1:0]  cnt_q;
    logic [SizeW-1:0] rem_in, quo_in, dvs_in, rem_nxt, quo_nxt;
    logic [SizeW:0]   shifted, trial;
    logic             running;

    assign running = (cnt_q != '0) && (cnt_q != CntW'(SizeW));

    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_in  = start ? divisor : dvs_q;
        shifted = {rem_in, quo_in[SizeW-1]};
        trial   = shifted - {1'b0, dvs_in};
        // A clear MSB on the trial subtraction means the divisor fits.
        if (!trial[SizeW]) begin
            rem_nxt = trial[SizeW-1:0];
            quo_nxt = {quo_in[SizeW-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[SizeW-1:0];
            quo_nxt = {quo_in[SizeW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            dvs_q <= divisor;
            cnt_q <= CntW'(1);
        end else if (running) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign q    = quo_q;
    assign r    = rem_q;
    assign done = (cnt_q == CntW'(SizeW));

endmodule

// File: rtl/redmule_tile_calc.sv
// Derives RedMulE tiling/iteration counts from the M/N/K job sizes with a
// shared sequential divider and an inline shift-add multiplier.
module redmule_tile_calc
    import redmule_pkg::*;
#(
    parameter int unsigned Height      = 4,
    parameter int unsigned Width       = 8,
    parameter int unsigned NumPipeRegs = 3,
    parameter int unsigned SizeW       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_cfg_i,
    input  logic             setback_i,
    input  logic [SizeW-1:0] m_size_i,
    input  logic [SizeW-1:0] n_size_i,
    input  logic [SizeW-1:0] k_size_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             cfg_err_o,
    output logic             ovf_o,
    output logic [SizeW-1:0] x_rows_iter_o,
    output logic [SizeW-1:0] x_rows_lftovr_o,
    output logic [SizeW-1:0] n_iters_o,
    output logic [SizeW-1:0] n_lftovr_o,
    output logic [SizeW-1:0] k_iters_o,
    output logic [SizeW-1:0] k_lftovr_o,
    output logic [SizeW-1:0] w_rows_iter_o,
    output logic [SizeW-1:0] tot_stores_o
);

    localparam int unsigned Tile  = (NumPipeRegs + 1) * Height;
    localparam int unsigned MCntW = (SizeW > 1) ? $clog2(SizeW) : 1;

    if ((Height == 0) || ((Height & (Height - 1)) != 0)) begin : g_bad_height
        $error("redmule_tile_calc: Height must be a power of two");
    end
    if (Width < 1) begin : g_bad_width
        $error("redmule_tile_calc: Width must be at least 1");
    end

    tile_calc_state_e state_q, state_d;

    logic [SizeW-1:0]   n_q, k_q;
    logic               div_start, div_done;
    logic [SizeW-1:0]   div_divisor, div_dividend, div_q, div_r, div_iters;
    logic [2*SizeW-1:0] prod_q, mcand_q, prod_nxt;
    logic [SizeW-1:0]   mplier_q;
    logic [MCntW-1:0]   mcnt_q;
    logic               mul_last, size_zero, valid_d;
    logic [SizeW:0]     w_sum;
    logic [SizeW-1:0]   w_rows;

    redmule_seq_divider #(
        .SizeW (SizeW)
    ) i_divider (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start    (div_start),
        .divisor  (div_divisor),
        .dividend (div_dividend),
        .q        (div_q),
        .r        (div_r),
        .done     (div_done)
    );

    assign div_iters = div_q + SizeW'(div_r != '0);
    assign size_zero = (m_size_i == '0) || (n_size_i == '0) || (k_size_i == '0);
    assign w_sum     = {1'b0, n_size_i} + (SizeW + 1)'(Height - 1);
    assign w_rows    = w_sum[SizeW] ? ~SizeW'(Height - 1)
                                    : (w_sum[SizeW-1:0] & ~SizeW'(Height - 1));
    assign prod_nxt  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last  = (mcnt_q == MCntW'(SizeW - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The divider is launched on the edge that enters each DIV state.
    always_comb begin
        state_d      = state_q;
        div_start    = 1'b0;
        div_divisor  = SizeW'(Width);
        div_dividend = m_size_i;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_cfg_i) begin
                    if (size_zero) begin
                        state_d = DONE;
                    end else begin
                        state_d   = DIV_M;
                        div_start = 1'b1;
                    end
                end else if ((state_q == DONE) && setback_i) begin
                    state_d = IDLE;
                end
            end
            DIV_M: begin
                if (div_done) begin
                    state_d      = DIV_N;
                    div_start    = 1'b1;
                    div_divisor  = SizeW'(Tile);
                    div_dividend = n_q;
                end
            end
            DIV_N: begin
                if (div_done) begin
                    state_d      = DIV_K;
                    div_start    = 1'b1;
                    div_divisor  = SizeW'(Tile);
                    div_dividend = k_q;
                end
            end
            DIV_K: begin
                if (div_done) state_d = MUL;
            end
            MUL: begin
                if (mul_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d   = IDLE;
            div_start = 1'b0;
        end
    end

    assign valid_d = (state_q == DONE) && (state_d == DONE) && !start_cfg_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || clear_i) begin
            n_q             <= '0;
            k_q             <= '0;
            prod_q          <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            mcnt_q          <= '0;
            valid_o         <= 1'b0;
            cfg_err_o       <= 1'b0;
            ovf_o           <= 1'b0;
            x_rows_iter_o   <= '0;
            x_rows_lftovr_o <= '0;
            n_iters_o       <= '0;
            n_lftovr_o      <= '0;
            k_iters_o       <= '0;
            k_lftovr_o      <= '0;
            w_rows_iter_o   <= '0;
            tot_stores_o    <= '0;
        end else begin
            valid_o <= valid_d;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_cfg_i) begin
                        n_q       <= n_size_i;
                        k_q       <= k_size_i;
                        cfg_err_o <= size_zero;
                        ovf_o     <= 1'b0;
                        if (size_zero) begin
                            x_rows_iter_o   <= '0;
                            x_rows_lftovr_o <= '0;
                            n_iters_o       <= '0;
                            n_lftovr_o      <= '0;
                            k_iters_o       <= '0;
                            k_lftovr_o      <= '0;
                            w_rows_iter_o   <= '0;
                            tot_stores_o    <= '0;
                        end else begin
                            w_rows_iter_o <= w_rows;
                        end
                    end
                end
                DIV_M: begin
                    if (div_done) begin
                        x_rows_iter_o   <= div_iters;
                        x_rows_lftovr_o <= div_r;
                    end
                end
                DIV_N: begin
                    if (div_done) begin
                        n_iters_o  <= div_iters;
                        n_lftovr_o <= div_r;
                    end
                end
                DIV_K: begin
                    if (div_done) begin
                        k_iters_o  <= div_iters;
                        k_lftovr_o <= div_r;
                        prod_q     <= '0;
                        mcand_q    <= {{SizeW{1'b0}}, x_rows_iter_o};
                        mplier_q   <= div_iters;
                        mcnt_q     <= '0;
                    end
                end
                MUL: begin
                    prod_q   <= prod_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    mcnt_q   <= mcnt_q + MCntW'(1);
                    if (mul_last) begin
                        if (prod_nxt[2*SizeW-1:SizeW] != '0) begin
                            tot_stores_o <= '1;
                            ovf_o        <= 1'b1;
                        end else begin
                            tot_stores_o <= prod_nxt[SizeW-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q == DIV_M) || (state_q == DIV_N) ||
                    (state_q == DIV_K) || (state_q == MUL);

endmodule

// File: tb/tb_redmule_tile_calc.sv
// Self-checking bench for redmule_tile_calc: directed scenarios plus random
// jobs compared against an arithmetic model of the tiling rules.
module tb_redmule_tile_calc;

    localparam int unsigned H    = 4;
    localparam int unsigned WD   = 8;
    localparam int unsigned NP   = 3;
    localparam int unsigned SW   = 16;
    localparam int unsigned TILE = (NP + 1) * H;
    localparam int          LAT  = 4 * SW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          setback = 1'b0;
    logic [SW-1:0] m_size = '0, n_size = '0, k_size = '0;
    logic          busy, valid, cfg_err, ovf;
    logic [SW-1:0] x_rows_iter, x_rows_lftovr, n_iters, n_lftovr;
    logic [SW-1:0] k_iters, k_lftovr, w_rows_iter, tot_stores;
    logic [8*SW+1:0] got;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    redmule_tile_calc #(
        .Height      (H),
        .Width       (WD),
        .NumPipeRegs (NP),
        .SizeW       (SW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear),
        .start_cfg_i     (start),
        .setback_i       (setback),
        .m_size_i        (m_size),
        .n_size_i        (n_size),
        .k_size_i        (k_size),
        .busy_o          (busy),
        .valid_o         (valid),
        .cfg_err_o       (cfg_err),
        .ovf_o           (ovf),
        .x_rows_iter_o   (x_rows_iter),
        .x_rows_lftovr_o (x_rows_lftovr),
        .n_iters_o       (n_iters),
        .n_lftovr_o      (n_lftovr),
        .k_iters_o       (k_iters),
        .k_lftovr_o      (k_lftovr),
        .w_rows_iter_o   (w_rows_iter),
        .tot_stores_o    (tot_stores)
    );

    assign got = {cfg_err, ovf, x_rows_iter, x_rows_lftovr, n_iters, n_lftovr,
                  k_iters, k_lftovr, w_rows_iter, tot_stores};

    // Expected {cfg_err, ovf, counts...} from plain integer arithmetic.
    function automatic logic [8*SW+1:0] model(input longint unsigned m, n, k);
        longint unsigned xi, ni, ki, w, p;
        logic o;
        if (m == 0 || n == 0 || k == 0) return {1'b1, {(8*SW+1){1'b0}}};
        xi = (m + WD - 1) / WD;
        ni = (n + TILE - 1) / TILE;
        ki = (k + TILE - 1) / TILE;
        w  = ((n + H - 1) / H) * H;
        if (w > 65535) w = 65536 - H;
        p  = xi * ki;
        o  = (p > 65535);
        if (o) p = 65535;
        return {1'b0, o, SW'(xi), SW'(m % WD), SW'(ni), SW'(n % TILE),
                SW'(ki), SW'(k % TILE), SW'(w), SW'(p)};
    endfunction

    task automatic do_start(input int unsigned m, n, k, input logic sb);
        @(negedge clk);
        m_size  = SW'(m);
        n_size  = SW'(n);
        k_size  = SW'(k);
        start   = 1'b1;
        setback = sb;
        @(negedge clk);
        start   = 1'b0;
        setback = 1'b0;
    endtask

    // Returns edges from the start edge until valid is seen (-1 on timeout).
    task automatic wait_valid(output int lat, output logic busy_seen);
        lat = -1;
        busy_seen = busy;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            busy_seen |= busy;
            if (valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, valid, got} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h busy=%b valid=%b required all zero", got, busy, valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, valid, got} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h busy=%b valid=%b required all zero", got, busy, valid);
        end
    endtask

    task automatic test_basic;
        int unsigned tbl[2][3] = '{'{32, 32, 32}, '{9, 17, 5}};
        int lat;
        logic bs;
        for (int i = 0; i < 2; i++) begin
            do_start(tbl[i][0], tbl[i][1], tbl[i][2], 1'b0);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL basic_busy case=%0d got=%b required=1", i, busy);
            end
            wait_valid(lat, bs);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL basic_latency case=%0d got=%0d required=%0d", i, lat, LAT);
            end
            checks++;
            if (got !== model(tbl[i][0], tbl[i][1], tbl[i][2])) begin
                failures++;
                $display("FAIL basic_results case=%0d got=%h required=%h", i, got,
                         model(tbl[i][0], tbl[i][1], tbl[i][2]));
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy_done case=%0d got=%b required=0", i, busy);
            end
        end
    endtask

    task automatic test_zero;
        int lat;
        logic bs;
        do_start(7, 40, 0, 1'b0);
        wait_valid(lat, bs);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL zero_latency got=%0d required=1", lat);
        end
        checks++;
        if (bs !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy got=%b required=0", bs);
        end
        checks++;
        if (got !== model(7, 40, 0)) begin
            failures++;
            $display("FAIL zero_results got=%h required=%h", got, model(7, 40, 0));
        end
    endtask

    task automatic test_overflow;
        int unsigned tbl[2][3] = '{'{65535, 1, 65535}, '{65535, 65535, 65535}};
        int lat;
        logic bs;
        for (int i = 0; i < 2; i++) begin
            do_start(tbl[i][0], tbl[i][1], tbl[i][2], 1'b0);
            wait_valid(lat, bs);
            checks++;
            if (lat !== LAT || got !== model(tbl[i][0], tbl[i][1], tbl[i][2])) begin
                failures++;
                $display("FAIL overflow_results case=%0d lat=%0d got=%h required=%h", i, lat, got,
                         model(tbl[i][0], tbl[i][1], tbl[i][2]));
            end
        end
    endtask

    task automatic test_clear;
        int lat;
        logic bs;
        do_start(100, 200, 300, 1'b0);
        repeat (19) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if ({busy, valid, got} !== '0) begin
            failures++;
            $display("FAIL clear_state got=%h busy=%b valid=%b required all zero", got, busy, valid);
        end
        do_start(50, 33, 77, 1'b0);
        wait_valid(lat, bs);
        checks++;
        if (lat !== LAT || got !== model(50, 33, 77)) begin
            failures++;
            $display("FAIL clear_recompute lat=%0d got=%h required=%h", lat, got, model(50, 33, 77));
        end
    endtask

    task automatic test_setback;
        logic [8*SW+1:0] held;
        held = got;
        @(negedge clk);
        setback = 1'b1;
        @(negedge clk);
        setback = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL setback_valid got valid=%b busy=%b required 0/0", valid, busy);
        end
        checks++;
        if (got !== model(50, 33, 77) || got !== held) begin
            failures++;
            $display("FAIL setback_hold got=%h required=%h", got, model(50, 33, 77));
        end
    endtask

    task automatic test_busy_ignore;
        int lat = -1;
        do_start(200, 64, 48, 1'b0);
        repeat (9) @(negedge clk);
        m_size = 16'd3;
        n_size = 16'd3;
        k_size = 16'd3;
        start = 1'b1;
        setback = 1'b1;
        @(negedge clk);
        start = 1'b0;
        setback = 1'b0;
        for (int i = 11; i <= 200; i++) begin
            @(negedge clk);
            if (valid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== LAT || got !== model(200, 64, 48)) begin
            failures++;
            $display("FAIL busy_ignore lat=%0d got=%h required=%h", lat, got, model(200, 64, 48));
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic bs;
        do_start(1000, 129, 31, 1'b1);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got valid=%b busy=%b required 0/1", valid, busy);
        end
        wait_valid(lat, bs);
        checks++;
        if (lat !== LAT || got !== model(1000, 129, 31)) begin
            failures++;
            $display("FAIL b2b_results lat=%0d got=%h required=%h", lat, got, model(1000, 129, 31));
        end
    endtask

    task automatic test_random;
        int lat;
        logic bs;
        int unsigned sz[3];
        for (int j = 0; j < 10; j++) begin
            for (int f = 0; f < 3; f++) begin
                case ($urandom_range(0, 3))
                    0: sz[f] = $urandom_range(1, 100);
                    1: sz[f] = $urandom_range(1, 65535);
                    2: sz[f] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
                    default: sz[f] = $urandom_range(60000, 65535);
                endcase
            end
            do_start(sz[0], sz[1], sz[2], 1'b0);
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL rand_valid_drop job=%0d got=%b required=0", j, valid);
            end
            wait_valid(lat, bs);
            checks++;
            if (lat !== ((sz[0] == 0 || sz[1] == 0 || sz[2] == 0) ? 1 : LAT) ||
                got !== model(sz[0], sz[1], sz[2])) begin
                failures++;
                $display("FAIL rand_job job=%0d m=%0d n=%0d k=%0d lat=%0d got=%h required=%h",
                         j, sz[0], sz[1], sz[2], lat, got, model(sz[0], sz[1], sz[2]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_clear();
        test_setback();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
